// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: input immediate stream, output result stream, status.
// slave is the unit side; master is the producer/consumer side.
interface imm_extend_pipe_if #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32,
   parameter int unsigned CNT_W = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             bad_mode;
   logic [CNT_W-1:0] xfer_count;

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, bad_mode, xfer_count
   );

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, bad_mode, xfer_count
   );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with a 2-entry skid buffer, sticky bad-mode flag and transfer count.
// Define IMM_EXT_LUI_EN to enable upper placement (mode 2); otherwise mode 2 is treated as reserved.
module imm_extend_pipe #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32,
   parameter int unsigned CNT_W = 16
) (
   input logic              clk,
   input logic              rst_n,
   imm_extend_pipe_if.slave bus
);
   localparam int unsigned PAD = OUT_W - IN_W;

   logic             mainValid_q, mainValid_d;
   logic [OUT_W-1:0] mainData_q, mainData_d;
   logic             skidValid_q, skidValid_d;
   logic [OUT_W-1:0] skidData_q, skidData_d;
   logic             inReady_q, inReady_d;
   logic             badMode_q, badMode_d;
   logic [CNT_W-1:0] xferCount_q, xferCount_d;

   logic             accept;
   logic             drain;
   logic [OUT_W-1:0] extData;
   logic             extBad;

   assign accept = bus.in_valid && inReady_q;
   assign drain  = mainValid_q && bus.out_ready;

   always_comb begin
      extData = {{PAD{1'b0}}, bus.in_data};
      extBad  = 1'b0;
      case (bus.in_mode)
         2'd0: extData = {{PAD{bus.in_data[IN_W-1]}}, bus.in_data};
         2'd1: extData = {{PAD{1'b0}}, bus.in_data};
`ifdef IMM_EXT_LUI_EN
         2'd2: extData = {bus.in_data, {PAD{1'b0}}};
`else
         2'd2: extBad = 1'b1;
`endif
         default: extBad = 1'b1;
      endcase
   end

   always_comb begin
      mainValid_d = mainValid_q;
      mainData_d  = mainData_q;
      skidValid_d = skidValid_q;
      skidData_d  = skidData_q;
      badMode_d   = badMode_q | (accept & extBad);
      xferCount_d = drain ? xferCount_q + CNT_W'(1) : xferCount_q;
      if (drain) begin
         if (skidValid_q) begin
            // Skid full implies in_ready was low, so no accept can coincide here.
            mainData_d  = skidData_q;
            skidValid_d = 1'b0;
         end else if (accept) begin
            mainData_d = extData;
         end else begin
            mainValid_d = 1'b0;
         end
      end else if (accept) begin
         if (!mainValid_q) begin
            mainValid_d = 1'b1;
            mainData_d  = extData;
         end else begin
            skidValid_d = 1'b1;
            skidData_d  = extData;
         end
      end
      inReady_d = !skidValid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mainValid_q <= 1'b0;
         mainData_q  <= '0;
         skidValid_q <= 1'b0;
         skidData_q  <= '0;
         inReady_q   <= 1'b1;
         badMode_q   <= 1'b0;
         xferCount_q <= '0;
      end else begin
         mainValid_q <= mainValid_d;
         mainData_q  <= mainData_d;
         skidValid_q <= skidValid_d;
         skidData_q  <= skidData_d;
         inReady_q   <= inReady_d;
         badMode_q   <= badMode_d;
         xferCount_q <= xferCount_d;
      end
   end

   assign bus.in_ready   = inReady_q;
   assign bus.out_valid  = mainValid_q;
   assign bus.out_data   = mainData_q;
   assign bus.bad_mode   = badMode_q;
   assign bus.xfer_count = xferCount_q;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed scenarios plus random traffic against a
// queue-based reference model; counter width reduced to 4 so the wrap is reachable.
module tb_imm_extend_pipe;
   localparam int unsigned IW = 16;
   localparam int unsigned OW = 32;
   localparam int unsigned CW = 4;
`ifdef IMM_EXT_LUI_EN
   localparam bit LuiEn = 1'b1;
`else
   localparam bit LuiEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   imm_extend_pipe_if #(.IN_W(IW), .OUT_W(OW), .CNT_W(CW)) bus ();

   imm_extend_pipe #(.IN_W(IW), .OUT_W(OW), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          checks = 0;
   int          passes = 0;
   logic [31:0] q[$];
   bit          mBad = 1'b0;
   int          mCnt = 0;

   function automatic logic [31:0] refExt(input logic [15:0] d, input logic [1:0] m);
      longint v = longint'(d);
      if (m == 2'd0 && v >= (longint'(1) << (IW - 1)))
         v = v + (longint'(1) << OW) - (longint'(1) << IW);
      else if (m == 2'd2 && LuiEn)
         v = v * (longint'(1) << (OW - IW));
      return v[31:0];
   endfunction

   function automatic bit isBad(input logic [1:0] m);
      return (m == 2'd3) || (m == 2'd2 && !LuiEn);
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance the model.
   task automatic step(input logic v, input logic [15:0] d, input logic [1:0] m,
                       input logic ordy);
      bit acc, drn;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_mode   = m;
      bus.out_ready = ordy;
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      if (q.size() > 0) chk("out_data", 64'(bus.out_data), 64'(q[0]));
      chk("bad_mode", 64'(bus.bad_mode), 64'(mBad));
      chk("xfer_count", 64'(bus.xfer_count), 64'(mCnt));
      acc = v && (q.size() < 2);
      drn = (q.size() > 0) && ordy;
      @(posedge clk);
      if (drn) begin
         void'(q.pop_front());
         mCnt = (mCnt + 1) % (1 << CW);
      end
      if (acc) begin
         q.push_back(refExt(d, m));
         if (isBad(m)) mBad = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_xfer_count", 64'(bus.xfer_count), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_bad_mode", 64'(bus.bad_mode), 64'd0);
      q.delete();
      mBad = 1'b0;
      mCnt = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_mode   = 2'd0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      doReset();

      // Streaming at full rate
      step(1'b1, 16'h854C, 2'd0, 1'b1);
      chk("stream_first", 64'(bus.out_data), 64'hFFFF854C);
      step(1'b1, 16'h854C, 2'd1, 1'b1);
      chk("stream_second", 64'(bus.out_data), 64'h0000854C);
      step(1'b1, 16'h7FFF, 2'd0, 1'b1);
      chk("stream_third", 64'(bus.out_data), 64'h00007FFF);
      step(1'b0, 16'h0000, 2'd0, 1'b1);
      chk("stream_count", 64'(bus.xfer_count), 64'd3);

      // Backpressure: three offered, two accepted
      step(1'b1, 16'h0001, 2'd0, 1'b0);
      step(1'b1, 16'h8002, 2'd0, 1'b0);
      step(1'b1, 16'h0003, 2'd1, 1'b0);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_hold_data", 64'(bus.out_data), 64'h00000001);
      for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 2'd0, 1'b1);
      chk("bp_in_ready_back", 64'(bus.in_ready), 64'd1);

      // Mode 2
      step(1'b1, 16'h1234, 2'd2, 1'b0);
      chk("mode2_data", 64'(bus.out_data), LuiEn ? 64'h12340000 : 64'h00001234);
      chk("mode2_bad", 64'(bus.bad_mode), LuiEn ? 64'd0 : 64'd1);
      step(1'b0, 16'h0000, 2'd0, 1'b1);

      // Mode 3 sets the sticky flag
      step(1'b1, 16'hF00D, 2'd3, 1'b1);
      chk("mode3_data", 64'(bus.out_data), 64'h0000F00D);
      chk("mode3_bad", 64'(bus.bad_mode), 64'd1);
      for (int i = 0; i < 3; i++) step(1'b1, 16'(i), 2'd0, 1'b1);
      chk("bad_sticky", 64'(bus.bad_mode), 64'd1);

      // Random traffic
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 3) != 0), 16'($urandom),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0));
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 2'd0, 1'b1);

      // Counter wrap: 17 handshakes on a 4-bit counter
      @(negedge clk);
      doReset();
      for (int i = 0; i < 17; i++) step(1'b1, 16'(i * 977), 2'd1, 1'b1);
      step(1'b0, 16'h0000, 2'd0, 1'b1);
      chk("wrap_count", 64'(bus.xfer_count), 64'd1);

      // Reset mid-stream with two items buffered
      step(1'b1, 16'hAAAA, 2'd0, 1'b0);
      step(1'b1, 16'h5555, 2'd1, 1'b0);
      chk("mid_full", 64'(bus.in_ready), 64'd0);
      doReset();
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 2'd0, 1'b1);
      chk("no_stale", 64'(bus.out_valid), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Pipelined, parametrised immediate-extension unit for the CPU datapath. It accepts `IN_W`-bit immediates with a per-item extension mode over a valid/ready handshake. It returns `OUT_W`-bit results one cycle later through a 2-entry skid buffer, so a stalled execute stage never loses an immediate. It replaces the fixed 16→32 combinational sign extender between decode and ALU operand select, and adds a zero-extend mode, an optional upper-placement (LUI) mode, a sticky bad-mode flag and a transfer counter.

## Interface
- `IN_W`, 16, input immediate width; must satisfy 1 ≤ `IN_W` < `OUT_W`
- `OUT_W`, 32, output width
- `CNT_W`, 16, width of the transfer counter
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  input item present
- `in_ready`  out  1  unit can accept; registered
- `in_data`  in  `IN_W`  immediate
- `in_mode`  in  2  0 = sign, 1 = zero, 2 = upper (LUI), 3 = reserved
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts
- `out_data`  out  `OUT_W`  extended result
- `bad_mode`  out  1  sticky: an unsupported mode was accepted
- `xfer_count`  out  `CNT_W`  number of completed output handshakes, modulo 2^`CNT_W`

## Operation
- Extension is computed on entry to the main register:
  - sign: `out[IN_W-1:0]` = in; upper bits = `in[IN_W-1]`. Example: 16'h854C → 32'hFFFF854C.
  - zero: upper bits = 0.
  - upper: `out` = in << (`OUT_W`-`IN_W`); lower bits 0.
  - reserved (3): result = zero-extend; sets `bad_mode`.
- Storage is a main register (drives `out_*`) plus one skid register; capacity is 2 items.
- Accept when `in_valid && in_ready`. Accepted data goes to the main register if it is empty or draining this cycle, else to skid.
- Output handshake when `out_valid && out_ready`. On handshake, skid (if full) moves to main; otherwise main refills from an input accepted in the same cycle, or empties.
- `in_ready` = !skid_full, registered.
- `xfer_count` increments on each output handshake and wraps from all-ones to 0.
- `bad_mode` sets on acceptance of an unsupported mode. It clears only on reset.
- Order is strictly FIFO; no item is dropped or duplicated.

## Timing
- Reset (async assert, sync deassert by the system): `out_valid`=0, `out_data`=0, `in_ready`=1, `bad_mode`=0, `xfer_count`=0. Both registers are emptied, and items in flight are discarded.
- Latency: item accepted at edge N appears with `out_valid`=1 after edge N. Throughput is 1 item/cycle while `out_ready`=1.
- Stall: with main full and `out_ready`=0, one more item is accepted into skid. `in_ready` is 0 from the next cycle.
- Full, with simultaneous accept and drain: not possible, since `in_ready`=0 when skid is full.
- Main full, skid empty, with simultaneous accept and drain: the new item enters main, and skid stays empty.
- `out_data` is held stable while `out_valid`=1 and `out_ready`=0.
- `in_valid` with `in_ready`=0 is ignored; no state changes.

## Configuration
- `IMM_EXT_LUI_EN`:
  - Defined: mode 2 performs upper placement.
  - Undefined: mode 2 is unsupported, so it behaves as mode 3: zero-extend and set `bad_mode`.

## Test plan
- Reset mid-stream with 2 items buffered, `rst_n`=0 → `out_valid`=0, `in_ready`=1 and `xfer_count`=0 immediately (asynchronously); after release, no stale items appear.
- Streaming, `out_ready`=1, inputs 16'h854C sign, 16'h854C zero, 16'h7FFF sign → outputs one cycle later: 32'hFFFF854C, 32'h0000854C, 32'h00007FFF; `xfer_count`=3.
- Backpressure: hold `out_ready`=0 and offer 3 items → 2 accepted and `in_ready`=0. Release → outputs in order, with `in_ready` returning to 1.
- Mode 2 with 16'h1234:
  - `IMM_EXT_LUI_EN` defined → 32'h12340000, `bad_mode`=0.
  - Undefined → 32'h00001234, `bad_mode`=1.
- Mode 3 → zero-extended result and `bad_mode`=1. `bad_mode` is still 1 after further valid-mode traffic.
- Counter wrap with `CNT_W`=4: 17 output handshakes → `xfer_count`=1.
